byte_mem_init: RTL
==================

BYTE_MEM_INIT -- requirements
Module: byte_mem_init

Interface
REQ-001 SHALL have parameter DEPTH, default 4096: number of byte entries.
REQ-002 SHALL have parameter AW, default 12: address width, with DEPTH == 2**AW.
REQ-003 SHALL have parameter FILL, default 8'hFF: initialisation byte.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous reset, active-high.
REQ-006 SHALL have port start, input, 1 bit: request a full fill sweep.
REQ-007 SHALL have port busy, output, 1 bit: high while a fill sweep is in progress.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse when a sweep completes.
REQ-009 SHALL have port wr_valid, input, 1 bit: write request.
REQ-010 SHALL have port wr_ready, output, 1 bit: write accepted when wr_valid and wr_ready are both high.
REQ-011 SHALL have ports wr_addr, input, AW bits, and wr_data, input, 8 bits: write address and write byte.
REQ-012 SHALL have ports rd_en, input, 1 bit, and rd_addr, input, AW bits: read request.
REQ-013 SHALL have port rd_data, output, 8 bits: read byte.
REQ-014 SHALL have port rd_valid, output, 1 bit: rd_data qualifier.
REQ-015 SHALL have port rd_undef, output, 1 bit: entry-undefined flag (see Configuration).

Function
REQ-016 SHALL contain internal storage of DEPTH x 8 bits.
REQ-017 SHALL implement states IDLE, FILL and READY.
REQ-018 SHALL move IDLE->FILL, and READY->FILL, on start=1; in FILL, start SHALL be ignored.
REQ-019 In FILL, SHALL write FILL to address cnt once per cycle, with cnt running 0..DEPTH-1; the sweep takes exactly DEPTH cycles.
REQ-020 On the cycle that writes DEPTH-1, SHALL set done=1 for one cycle, and SHALL be in READY on the next cycle; cnt SHALL wrap to 0.
REQ-021 busy SHALL be 1 exactly while in FILL; wr_ready SHALL be 1 exactly while in READY.
REQ-022 A write accepted in READY SHALL update the addressed entry at that clock edge.
REQ-023 rd_valid SHALL be 1 in cycle t+1 exactly when rd_en=1 and the state is READY in cycle t; rd_data SHALL then hold that entry, giving a latency of 1.
REQ-024 When rd_valid=0, rd_data SHALL hold its previous value.
REQ-025 A read and a write to the same address in the same cycle SHALL return the old contents (read-first).
REQ-026 wr_valid asserted outside READY SHALL be held off (wr_ready=0) and SHALL NOT modify storage.
REQ-027 When start and a write arrive in the same READY cycle, SHALL accept the write and begin FILL on the next cycle.

Reset
REQ-028 While rst=1: state SHALL be IDLE, cnt=0, busy=0, done=0, wr_ready=0, rd_valid=0, rd_data=0, rd_undef=0.
REQ-029 Reset SHALL NOT clear storage contents.
REQ-030 Reset asserted mid-FILL SHALL abort the sweep immediately; a later start SHALL restart from address 0.

Configuration
REQ-031 Macro BYTE_MEM_INIT_UNDEF_TRACK_EN defined: bit0 of each entry SHALL be a defined flag; the fill SHALL write {FILL[7:1],1'b0}; accepted writes SHALL store {wr_data[7:1],1'b1}; rd_undef SHALL equal ~rd_data[0] whenever rd_valid=1.
REQ-032 Macro BYTE_MEM_INIT_UNDEF_TRACK_EN undefined: fill and writes SHALL store data unmodified, and rd_undef SHALL be constant 0.

Verification
REQ-033 Reset, then start pulse: busy=1 for exactly 4096 cycles, a single done pulse, then wr_ready=1; reads of addresses 0, 2047 and 4095 return 8'hFF (8'hFE with rd_undef=1 when the macro is defined).
REQ-034 In READY, write 8'hA5 to address 12'h123, then read it: rd_valid and rd_data=8'hA5 one cycle after rd_en (8'hA5 with rd_undef=0 when the macro is defined).
REQ-035 Same-cycle read and write of 8'h3C to address 7, whose old value is 8'hFF: read returns 8'hFF; the following read returns 8'h3C (8'h3D when the macro is defined).
REQ-036 Assert rst at cnt=1000, then start: busy lasts 4096 cycles counted from the new start; wr_valid held high during FILL produces no accepted write.
REQ-037 rd_en during FILL: rd_valid stays 0; start pulsed during FILL: sweep length unchanged, exactly one done pulse.

Source files
------------

// File: rtl/byte_mem_init.sv
// byte_mem_init: DEPTH x 8 byte store with a FILL-byte initialisation sweep.
// Optional undefined-entry tracking: BYTE_MEM_INIT_UNDEF_TRACK_EN.
module byte_mem_init #(
  parameter int         DEPTH = 4096,
  parameter int         AW    = 12,
  parameter logic [7:0] FILL  = 8'hFF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          rd_valid,
  output logic          rd_undef
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_READY
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_cnt;
  logic          r_busy;
  logic          r_done;
  logic          r_wr_ready;
  logic          r_rd_valid;
  logic [7:0]    r_rd_data;
  logic [7:0]    r_mem [DEPTH];

  logic          w_in_fill;
  logic          w_in_ready;
  logic          w_last;
  logic          w_wr_acc;
  logic          w_rd_acc;
  logic          w_mem_we;
  logic [AW-1:0] w_mem_addr;
  logic [7:0]    w_mem_din;
  logic [7:0]    w_fill_byte;
  logic [7:0]    w_wr_byte;

`ifdef BYTE_MEM_INIT_UNDEF_TRACK_EN
  // bit0 marks an entry as written by a client (1) or only filled (0)
  logic r_rd_undef;
  assign w_fill_byte = FILL & 8'hFE;
  assign w_wr_byte   = wr_data | 8'h01;
  assign rd_undef    = r_rd_undef;
`else
  assign w_fill_byte = FILL;
  assign w_wr_byte   = wr_data;
  assign rd_undef    = 1'b0;
`endif

  assign w_in_fill  = (r_state == S_FILL);
  assign w_in_ready = (r_state == S_READY);
  assign w_last     = (r_cnt == AW'(DEPTH - 1));
  assign w_wr_acc   = wr_valid & w_in_ready;
  assign w_rd_acc   = rd_en & w_in_ready;

  assign w_mem_we   = w_in_fill | w_wr_acc;
  assign w_mem_addr = w_in_fill ? r_cnt : wr_addr;
  assign w_mem_din  = w_in_fill ? w_fill_byte : w_wr_byte;

  assign busy     = r_busy;
  assign done     = r_done;
  assign wr_ready = r_wr_ready;
  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_wr_ready <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE, S_READY: begin
          if (start) begin
            r_state    <= S_FILL;
            r_busy     <= 1'b1;
            r_wr_ready <= 1'b0;
          end
        end
        S_FILL: begin
          // cnt wraps back to 0 after the last address
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == AW'(DEPTH - 2)) begin
            r_done <= 1'b1;
          end
          if (w_last) begin
            r_state    <= S_READY;
            r_busy     <= 1'b0;
            r_wr_ready <= 1'b1;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_busy     <= 1'b0;
          r_wr_ready <= 1'b0;
        end
      endcase
    end
  end

  // storage is deliberately outside reset
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= 8'h00;
    end else begin
      r_rd_valid <= w_rd_acc;
      if (w_rd_acc) begin
        r_rd_data <= r_mem[rd_addr];
      end
    end
  end

`ifdef BYTE_MEM_INIT_UNDEF_TRACK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_undef <= 1'b0;
    end else if (w_rd_acc) begin
      r_rd_undef <= ~r_mem[rd_addr][0];
    end
  end
`endif

endmodule
